game_scheduler: RTL and testbench
=================================

GAME_SCHEDULER -- requirements
Module: game_scheduler

Interface
REQ-001 The parameter SPEED_INIT SHALL default to 4 and gives the scroll speed in pixels per frame at game start.
REQ-002 The parameter SPEED_MAX SHALL default to 12 and gives the speed saturation value.
REQ-003 The parameter RAMP_FRAMES SHALL default to 600 and gives the number of running frames between speed increments.
REQ-004 The parameter TILE_W SHALL default to 40 and gives the ground tile width in pixels, which is the modulus of ground_position.
REQ-005 The parameter TICK_ROW SHALL default to 480 and gives the row_addr value at which the frame tick fires.
REQ-006 Port CLK SHALL be an input, 1 bit wide: the single system clock.
REQ-007 Port rst SHALL be an input, 1 bit wide: synchronous, active-high reset.
REQ-008 Port row_addr SHALL be an input, 9 bits wide: the VGA scan row.
REQ-009 Port col_addr SHALL be an input, 10 bits wide: the VGA scan column.
REQ-010 Port start SHALL be an input, 1 bit wide: a level-sensitive player button, already debounced.
REQ-011 Port collision SHALL be an input, 1 bit wide: the level from the dino/obstacle overlap logic.
REQ-012 Port game_status SHALL be an output, 1 bit wide: 1 only while the game is running.
REQ-013 Port speed SHALL be an output, 4 bits wide: the current scroll speed in pixels per frame.
REQ-014 Port ground_position SHALL be an output, 6 bits wide: the scroll offset, in the range 0..TILE_W-1.
REQ-015 Port frame_tick SHALL be an output, 1 bit wide: a one-cycle pulse issued once per frame.
REQ-016 Port score SHALL be an output, 16 bits wide: four BCD digits, with the most significant digit in score[15:12].
REQ-017 Port game_over SHALL be an output, 1 bit wide: 1 while the block is in the OVER state.

Function
REQ-018 frame_tick SHALL be registered and go high for exactly one cycle, in the cycle after the one in which row_addr==TICK_ROW and col_addr==0; it SHALL fire in every state.
REQ-019 The block SHALL register start and detect its rising edge (start_rise = start & ~start_q); a held button SHALL produce only one edge.
REQ-020 The state machine SHALL have three states: IDLE, RUN and OVER.
- game_status SHALL be 1 only in RUN.
- game_over SHALL be 1 only in OVER.
REQ-021 From IDLE, start_rise SHALL move the block to RUN; all other inputs SHALL be ignored in IDLE.
REQ-022 In RUN, collision==1 SHALL move the block to OVER on the next edge; start_rise SHALL be ignored in RUN.
REQ-023 From OVER, start_rise SHALL move the block to RUN; collision SHALL be ignored in OVER.
REQ-024 On every transition into RUN, the following SHALL be loaded in the same cycle:
- speed = SPEED_INIT
- ground_position = 0
- score = 0
- ramp counter = 0
REQ-025 In RUN, on a cycle with frame_tick=1 and collision=0, ground_position SHALL be set to ground_position+speed, minus TILE_W if the sum is ≥ TILE_W; the sum SHALL be computed at 7 bits (maximum 39+15=54) with no overflow.
REQ-026 On the same tick, the ramp counter SHALL increment; on reaching RAMP_FRAMES-1 it SHALL wrap to 0, and speed SHALL increment and saturate at SPEED_MAX.
REQ-027 On the same tick, score SHALL increment by 1 in BCD, with a carry per digit from 9 to 0; at 9999 it SHALL saturate and not wrap.
REQ-028 If collision and frame_tick are both 1 in RUN in the same cycle, collision SHALL win: the state goes to OVER and no position, speed or score update occurs.
REQ-029 In IDLE and OVER, speed, ground_position and score SHALL hold their values; OVER therefore freezes the final score and scroll on screen.
REQ-030 All outputs SHALL be registered, with no combinational path from any input to any output.

Reset
REQ-031 While rst=1 at a CLK edge, the block SHALL set:
- state = IDLE
- game_status = 0, game_over = 0
- speed = SPEED_INIT
- ground_position = 0
- score = 16'h0000
- frame_tick = 0
- ramp counter = 0
- start_q = 1
REQ-032 Setting start_q=1 at reset SHALL ensure that a button held through reset does not start the game.
REQ-033 Reset asserted mid-RUN SHALL take priority over every other event, including collision and frame_tick.

Structure
REQ-034 The state encoding (IDLE=2'd0, RUN=2'd1, OVER=2'd2) and the defaults for SPEED_INIT, SPEED_MAX, RAMP_FRAMES, TILE_W and TICK_ROW SHALL live in the shared game package; the ground and dino renderers SHALL use the same package.
REQ-035 The BCD score counter SHALL be a single sub-module, bcd4_counter, with ports CLK, clr, inc and q[15:0], and saturating behaviour.
REQ-036 The ground renderer SHALL consume game_status, speed and ground_position from this block and SHALL no longer own the scroll state.

Verification
REQ-037 Scenario: reset, then start pulsed for 1 cycle -> state goes to RUN one cycle later; game_status=1, speed=4, ground_position=0, score=0.
REQ-038 Scenario: in RUN with speed=4, ground_position=36, one frame_tick -> ground_position=0 and score increments by 1.
REQ-039 Scenario: in RUN, 600 frame ticks -> speed=5; after 8×600 ticks -> speed=12, and it stays 12 after a further 600 ticks.
REQ-040 Scenario: in RUN with score=0x0099, one tick -> score=0x0100; with score=0x9999, one tick -> score stays 0x9999.
REQ-041 Scenario: collision and frame_tick in the same cycle with ground_position=10 -> state becomes OVER, ground_position stays 10, score is unchanged, game_status=0; start held high across the transition produces no restart until it is released and pressed again, after which score=0.
REQ-042 Scenario: rst asserted for 1 cycle mid-RUN with score=0x0042 -> state becomes IDLE, score=0, speed=4; start held through reset produces no RUN.

Source files
------------

// File: rtl/game_scheduler_pkg.sv
// game_scheduler_pkg: shared state encoding, game defaults and BCD helper for the game blocks
package game_scheduler_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, OVER = 2'd2} state_t;
  localparam int SPEED_INIT_D  = 4;
  localparam int SPEED_MAX_D   = 12;
  localparam int RAMP_FRAMES_D = 600;
  localparam int TILE_W_D      = 40;
  localparam int TICK_ROW_D    = 480;
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic c;
    r = v;
    c = 1'b1;
    if (v == 16'h9999) return v;
    for (int i = 0; i < 4; i++) begin
      if (c) begin
        if (r[i*4 +: 4] == 4'd9) r[i*4 +: 4] = 4'd0;
        else begin
          r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction
endpackage

// File: rtl/game_scheduler_bcd4_counter.sv
// bcd4_counter: four-digit BCD counter with synchronous clear and saturation at 9999
module bcd4_counter
  import game_scheduler_pkg::*;
(
  input  logic        CLK,
  input  logic        clr,
  input  logic        inc,
  output logic [15:0] q
);
  // clear wins over increment; increment stops at 9999
  always_ff @(posedge CLK)
    q <= clr ? 16'h0000 : inc ? bcd_inc(q) : q;
endmodule

// File: rtl/game_scheduler.sv
// game_scheduler: game state machine, frame tick, scroll speed ramp, ground offset and score
module game_scheduler
  import game_scheduler_pkg::*;
#(
  parameter int SPEED_INIT  = SPEED_INIT_D,
  parameter int SPEED_MAX   = SPEED_MAX_D,
  parameter int RAMP_FRAMES = RAMP_FRAMES_D,
  parameter int TILE_W      = TILE_W_D,
  parameter int TICK_ROW    = TICK_ROW_D
) (
  input  logic        CLK,
  input  logic        rst,
  input  logic [8:0]  row_addr,
  input  logic [9:0]  col_addr,
  input  logic        start,
  input  logic        collision,
  output logic        game_status,
  output logic [3:0]  speed,
  output logic [5:0]  ground_position,
  output logic        frame_tick,
  output logic [15:0] score,
  output logic        game_over
);
  localparam int RW = $clog2(RAMP_FRAMES);
  localparam logic [RW-1:0] RAMP_LAST = RW'(RAMP_FRAMES - 1);
  localparam logic [3:0] S_INIT = 4'(SPEED_INIT);
  localparam logic [3:0] S_MAX = 4'(SPEED_MAX);
  localparam logic [6:0] TW = 7'(TILE_W);
  localparam logic [8:0] T_ROW = 9'(TICK_ROW);
  state_t state;
  logic start_q;
  logic [RW-1:0] ramp;
  logic start_rise, enter_run, step;
  logic [6:0] sum;
  assign start_rise = start & ~start_q;
  assign enter_run = (state != RUN) && start_rise;
  assign step = (state == RUN) && frame_tick && !collision;
  assign sum = {1'b0, ground_position} + {3'b000, speed};
  // state machine plus scroll/speed registers; a start edge reloads everything, collision beats the tick
  always_ff @(posedge CLK) begin
    if (rst) begin
      state <= IDLE;
      game_status <= 1'b0;
      game_over <= 1'b0;
      speed <= S_INIT;
      ground_position <= 6'd0;
      frame_tick <= 1'b0;
      ramp <= '0;
      start_q <= 1'b1;
    end else begin
      frame_tick <= (row_addr == T_ROW) && (col_addr == 10'd0);
      start_q <= start;
      if (enter_run) begin
        state <= RUN;
        game_status <= 1'b1;
        game_over <= 1'b0;
        speed <= S_INIT;
        ground_position <= 6'd0;
        ramp <= '0;
      end else if (state == RUN && collision) begin
        state <= OVER;
        game_status <= 1'b0;
        game_over <= 1'b1;
      end else if (step) begin
        ground_position <= 6'(sum >= TW ? sum - TW : sum);
        ramp <= ramp == RAMP_LAST ? '0 : ramp + 1'b1;
        if (ramp == RAMP_LAST && speed < S_MAX) speed <= speed + 4'd1;
      end
    end
  end
  bcd4_counter u_score (
    .CLK(CLK),
    .clr(rst | enter_run),
    .inc(step),
    .q  (score)
  );
endmodule

// File: tb/tb_game_scheduler.sv
// tb_game_scheduler: table-driven directed check of game_scheduler
module tb_game_scheduler;
  logic CLK = 1'b0;
  logic rst, start, collision;
  logic [8:0] row_addr;
  logic [9:0] col_addr;
  logic game_status, frame_tick, game_over;
  logic [3:0] speed;
  logic [5:0] ground_position;
  logic [15:0] score;
  int total = 0;
  int bad = 0;

  typedef struct {
    logic r, s, c;
    logic [1:0] tm;
    int n;
    logic st, ov;
    logic [3:0] sp;
    logic [5:0] gp;
    logic [15:0] sc;
    logic ft;
  } vec_t;

  vec_t tv[25];

  game_scheduler dut (
    .CLK(CLK), .rst(rst), .row_addr(row_addr), .col_addr(col_addr),
    .start(start), .collision(collision), .game_status(game_status),
    .speed(speed), .ground_position(ground_position), .frame_tick(frame_tick),
    .score(score), .game_over(game_over)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input int idx, input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL vec%0d %s: got %h expected %h", idx, nm, act, exp);
    end
  endtask

  initial begin
    // r s c tm n | status over speed gp score ft
    tv[0]  = '{1, 1, 0, 0, 2,    0, 0, 4,  0,  16'h0000, 0};
    tv[1]  = '{0, 1, 1, 1, 3,    0, 0, 4,  0,  16'h0000, 1};
    tv[2]  = '{0, 0, 0, 2, 1,    0, 0, 4,  0,  16'h0000, 0};
    tv[3]  = '{0, 1, 0, 0, 1,    1, 0, 4,  0,  16'h0000, 0};
    tv[4]  = '{0, 1, 0, 1, 100,  1, 0, 4,  36, 16'h0099, 1};
    tv[5]  = '{0, 0, 0, 1, 1,    1, 0, 4,  0,  16'h0100, 1};
    tv[6]  = '{0, 0, 0, 1, 500,  1, 0, 5,  0,  16'h0600, 1};
    tv[7]  = '{0, 0, 0, 1, 4200, 1, 0, 12, 0,  16'h4800, 1};
    tv[8]  = '{0, 0, 0, 1, 600,  1, 0, 12, 0,  16'h5400, 1};
    tv[9]  = '{0, 0, 0, 1, 4599, 1, 0, 12, 28, 16'h9999, 1};
    tv[10] = '{0, 0, 0, 1, 1,    1, 0, 12, 0,  16'h9999, 1};
    tv[11] = '{0, 0, 1, 1, 1,    0, 1, 12, 0,  16'h9999, 1};
    tv[12] = '{0, 0, 1, 1, 5,    0, 1, 12, 0,  16'h9999, 1};
    tv[13] = '{0, 1, 0, 1, 1,    1, 0, 4,  0,  16'h0000, 1};
    tv[14] = '{0, 0, 0, 1, 602,  1, 0, 5,  10, 16'h0602, 1};
    tv[15] = '{0, 1, 1, 1, 1,    0, 1, 5,  10, 16'h0602, 1};
    tv[16] = '{0, 1, 0, 1, 3,    0, 1, 5,  10, 16'h0602, 1};
    tv[17] = '{0, 0, 0, 1, 1,    0, 1, 5,  10, 16'h0602, 1};
    tv[18] = '{0, 1, 0, 1, 1,    1, 0, 4,  0,  16'h0000, 1};
    tv[19] = '{0, 0, 0, 1, 42,   1, 0, 4,  8,  16'h0042, 1};
    tv[20] = '{1, 1, 1, 1, 1,    0, 0, 4,  0,  16'h0000, 0};
    tv[21] = '{0, 1, 0, 1, 3,    0, 0, 4,  0,  16'h0000, 1};
    tv[22] = '{0, 0, 0, 0, 1,    0, 0, 4,  0,  16'h0000, 0};
    tv[23] = '{0, 0, 0, 1, 1,    0, 0, 4,  0,  16'h0000, 1};
    tv[24] = '{0, 0, 0, 0, 1,    0, 0, 4,  0,  16'h0000, 0};
    for (int i = 0; i < 25; i++) begin
      rst = tv[i].r;
      start = tv[i].s;
      collision = tv[i].c;
      row_addr = tv[i].tm == 2'd0 ? 9'd0 : 9'd480;
      col_addr = tv[i].tm == 2'd2 ? 10'd1 : 10'd0;
      repeat (tv[i].n) @(posedge CLK);
      #1;
      chk(i, "game_status", {15'd0, game_status}, {15'd0, tv[i].st});
      chk(i, "game_over", {15'd0, game_over}, {15'd0, tv[i].ov});
      chk(i, "speed", {12'd0, speed}, {12'd0, tv[i].sp});
      chk(i, "ground_position", {10'd0, ground_position}, {10'd0, tv[i].gp});
      chk(i, "score", score, tv[i].sc);
      chk(i, "frame_tick", {15'd0, frame_tick}, {15'd0, tv[i].ft});
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
